vga_sync_decoder: RTL and testbench

Recovers raster coordinates and frame timing from an incoming hsync/vsync pair in the VGA pixel-clock domain. It is the receive-side counterpart of our VGA timing generator, used for loopback checking of the display path and for tracking externally timed video. It measures line length, sync widths and frame height, declares lock after consistent frames, and regenerates `x_poi`/`y_poi`/`is_display` aligned to the source.

---
 rtl/vga_sync_decoder.sv | 138 +++++++++++++
 tb/tb_vga_sync_decoder.sv | 200 ++++++++++++++++++++
 2 files changed

// File: rtl/vga_sync_decoder.sv
// Recovers raster position, line/frame timing and lock from an active-low hsync/vsync pair.
// Outputs trail the source generator's counters by two vga_clk cycles; there is no backpressure.
module vga_sync_decoder #(
  parameter int X_BEFORE     = 144,
  parameter int X_ACTIVE_END = 784,
  parameter int Y_BEFORE     = 35,
  parameter int Y_ACTIVE_END = 515
) (
  input  logic        vga_clk,
  input  logic        rst_n,
  input  logic        hsync_in,
  input  logic        vsync_in,
  output logic [11:0] x_poi,
  output logic [11:0] y_poi,
  output logic        is_display,
  output logic        locked,
  output logic [11:0] h_total,
  output logic [11:0] h_sync_w,
  output logic [11:0] v_total,
  output logic [11:0] v_sync_w,
  output logic        fmt_err
);
  localparam logic [11:0] CNT_MAX = 12'hfff;
  localparam logic [11:0] XB = 12'(X_BEFORE);
  localparam logic [11:0] XE = 12'(X_ACTIVE_END);
  localparam logic [11:0] YB = 12'(Y_BEFORE);
  localparam logic [11:0] YE = 12'(Y_ACTIVE_END);

  logic        hs1, hs2, vs1, vs2;
  logic        h_fall, h_rise, v_fall, v_rise;
  logic [11:0] x_inc, y_inc, x_nxt, y_nxt;
  logic        seen_vfall, frame_ok, len_vld, sw_vld;
  logic [11:0] ref_len, ref_sw, cur_vsw;
  logic [1:0]  match_cnt, match_nxt;
  logic        len_bad, sw_bad, line_err, x_hit, y_hit;
  logic        lose_lock, complete, same_set, locked_nxt, win_nxt;

  assign h_fall = hs2 & ~hs1;
  assign h_rise = ~hs2 & hs1;
  assign v_fall = vs2 & ~vs1;
  assign v_rise = ~vs2 & vs1;

  // Saturating +1; doubles as "length = count + 1" for every measurement.
  assign x_inc = (x_poi == CNT_MAX) ? CNT_MAX : x_poi + 12'd1;
  assign y_inc = (y_poi == CNT_MAX) ? CNT_MAX : y_poi + 12'd1;
  assign x_nxt = h_fall ? 12'd0 : x_inc;
  assign y_nxt = v_fall ? 12'd0 : (h_fall ? y_inc : y_poi);

  assign x_hit = (x_nxt == CNT_MAX) && (x_poi != CNT_MAX);
  assign y_hit = (y_nxt == CNT_MAX) && (y_poi != CNT_MAX);

  assign len_bad  = h_fall & len_vld & (x_inc != ref_len);
  assign sw_bad   = h_rise & sw_vld & (x_inc != ref_sw);
  assign line_err = len_bad | sw_bad;

  assign lose_lock = (line_err & locked) | x_hit | y_hit;
  assign complete  = seen_vfall & frame_ok & ~line_err & ~x_hit & ~y_hit;
  assign same_set  = (ref_len == h_total) && (ref_sw == h_sync_w) &&
                     (y_inc == v_total) && (cur_vsw == v_sync_w);

  always_comb begin
    match_nxt = match_cnt;
    if (lose_lock) begin
      match_nxt = 2'd0;
    end else if (v_fall) begin
      if (!complete) begin
        match_nxt = 2'd0;
      end else if (same_set) begin
        match_nxt = (match_cnt == 2'd2) ? 2'd2 : match_cnt + 2'd1;
      end else begin
        match_nxt = 2'd1;
      end
    end
  end

  assign locked_nxt = (match_nxt == 2'd2);
  assign win_nxt    = (x_nxt >= XB) && (x_nxt < XE) && (y_nxt >= YB) && (y_nxt < YE);

  always_ff @(posedge vga_clk or negedge rst_n) begin
    if (!rst_n) begin
      // Sync pipes idle high so release does not fabricate an edge.
      hs1        <= 1'b1;
      hs2        <= 1'b1;
      vs1        <= 1'b1;
      vs2        <= 1'b1;
      x_poi      <= '0;
      y_poi      <= '0;
      is_display <= 1'b0;
      locked     <= 1'b0;
      h_total    <= '0;
      h_sync_w   <= '0;
      v_total    <= '0;
      v_sync_w   <= '0;
      fmt_err    <= 1'b0;
      match_cnt  <= '0;
      seen_vfall <= 1'b0;
      frame_ok   <= 1'b0;
      len_vld    <= 1'b0;
      sw_vld     <= 1'b0;
      ref_len    <= '0;
      ref_sw     <= '0;
      cur_vsw    <= '0;
    end else begin
      hs1        <= hsync_in;
      hs2        <= hs1;
      vs1        <= vsync_in;
      vs2        <= vs1;
      x_poi      <= x_nxt;
      y_poi      <= y_nxt;
      fmt_err    <= lose_lock;
      match_cnt  <= match_nxt;
      locked     <= locked_nxt;
      is_display <= locked_nxt & win_nxt;
      if (v_rise) cur_vsw <= y_inc;
      if (v_fall) begin
        // Close the frame: publish its measurement set and rearm the per-frame references.
        seen_vfall <= 1'b1;
        frame_ok   <= 1'b1;
        len_vld    <= 1'b0;
        sw_vld     <= 1'b0;
        h_total    <= ref_len;
        h_sync_w   <= ref_sw;
        v_total    <= y_inc;
        v_sync_w   <= cur_vsw;
      end else begin
        if (line_err | x_hit | y_hit) frame_ok <= 1'b0;
        if (h_fall && !len_vld) begin
          ref_len <= x_inc;
          len_vld <= 1'b1;
        end
        if (h_rise && !sw_vld) begin
          ref_sw <= x_inc;
          sw_vld <= 1'b1;
        end
      end
    end
  end
endmodule

// File: tb/tb_vga_sync_decoder.sv
// Drives a scaled raster generator into vga_sync_decoder and scoreboards the 2-cycle-delayed outputs.
module tb_vga_sync_decoder;
  localparam int XB = 10;
  localparam int XE = 34;
  localparam int YB = 4;
  localparam int YE = 28;

  logic        vga_clk = 1'b0;
  logic        rst_n;
  logic        hsync_in, vsync_in;
  logic [11:0] x_poi, y_poi, h_total, h_sync_w, v_total, v_sync_w;
  logic        is_display, locked, fmt_err;

  vga_sync_decoder #(
    .X_BEFORE(XB), .X_ACTIVE_END(XE), .Y_BEFORE(YB), .Y_ACTIVE_END(YE)
  ) dut (
    .vga_clk(vga_clk), .rst_n(rst_n), .hsync_in(hsync_in), .vsync_in(vsync_in),
    .x_poi(x_poi), .y_poi(y_poi), .is_display(is_display), .locked(locked),
    .h_total(h_total), .h_sync_w(h_sync_w), .v_total(v_total), .v_sync_w(v_sync_w),
    .fmt_err(fmt_err)
  );

  always #5 vga_clk = ~vga_clk;

  typedef struct {
    int x;
    int y;
    bit lck;
    bit fmt;
  } exp_t;

  exp_t q[$];
  int   errors = 0, checks = 0;
  int   h_tot = 40, h_sw = 6, v_tot = 30, v_sw = 2;
  int   gx = 0, gy = 0, starts = 0, good = 0, nfmt = 0;
  int   short_y = -1;
  bit   exp_lock = 0, chk_en = 0, hit_next = 0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
    checks++;
    assert (obs === expv) else begin
      errors++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, expv);
    end
  endtask

  function automatic bit disp_of(input exp_t e);
    return e.lck && e.x >= XB && e.x < XE && e.y >= YB && e.y < YE;
  endfunction

  // One clock: compare the entry driven two edges ago, then drive the next generator state.
  task automatic cycle(input bit stall);
    exp_t e;
    int   llen;
    @(posedge vga_clk);
    #1;
    if (fmt_err === 1'b1) nfmt++;
    if (chk_en && q.size() >= 2) begin
      e = q.pop_front();
      chk("x_poi", x_poi, e.x);
      chk("y_poi", y_poi, e.y);
      chk("locked", locked, e.lck);
      chk("fmt_err", fmt_err, e.fmt);
      chk("is_display", is_display, disp_of(e));
    end
    if (stall) begin
      hsync_in = 1'b1;
      return;
    end
    e.fmt = 1'b0;
    if (gx == 0 && gy == 0) begin
      starts++;
      good++;
      exp_lock = (good >= 3);
    end
    if (gx == 0 && hit_next) begin
      hit_next = 0;
      good     = 0;
      exp_lock = 0;
      e.fmt    = 1'b1;
    end
    hsync_in = (gx < h_sw) ? 1'b0 : 1'b1;
    vsync_in = (gy < v_sw) ? 1'b0 : 1'b1;
    e.x   = gx;
    e.y   = gy;
    e.lck = exp_lock;
    q.push_back(e);
    llen = (gy == short_y) ? h_tot - 1 : h_tot;
    gx++;
    if (gx == llen) begin
      if (gy == short_y) begin
        short_y  = -1;
        hit_next = 1;
      end
      gx = 0;
      gy = (gy == v_tot - 1) ? 0 : gy + 1;
    end
  endtask

  task automatic run_starts(input int n);
    int target;
    target = starts + n;
    while (starts < target) cycle(1'b0);
  endtask

  task automatic chk_zero(input string tag);
    chk({tag, ".x_poi"}, x_poi, 0);
    chk({tag, ".y_poi"}, y_poi, 0);
    chk({tag, ".locked"}, locked, 0);
    chk({tag, ".is_display"}, is_display, 0);
    chk({tag, ".h_total"}, h_total, 0);
    chk({tag, ".h_sync_w"}, h_sync_w, 0);
    chk({tag, ".v_total"}, v_total, 0);
    chk({tag, ".v_sync_w"}, v_sync_w, 0);
    chk({tag, ".fmt_err"}, fmt_err, 0);
  endtask

  task automatic chk_meas(input string tag, input int ht, input int hs, input int vt, input int vs);
    chk({tag, ".h_total"}, h_total, ht);
    chk({tag, ".h_sync_w"}, h_sync_w, hs);
    chk({tag, ".v_total"}, v_total, vt);
    chk({tag, ".v_sync_w"}, v_sync_w, vs);
  endtask

  initial begin
    // Reset from power-up with idle syncs.
    rst_n    = 1'b1;
    hsync_in = 1'b1;
    vsync_in = 1'b1;
    #2 rst_n = 1'b0;
    repeat (3) @(posedge vga_clk);
    #1;
    chk_zero("reset");
    rst_n  = 1'b1;
    chk_en = 1;

    // Acquire lock at the third frame start, then scoreboard one full locked frame.
    run_starts(5);
    repeat (3) cycle(1'b0);
    chk_meas("lock1", 40, 6, 30, 2);

    // One short line while locked: fmt_err pulse, lock lost, relock after the scoreboard's frames.
    short_y = 10;
    run_starts(4);
    chk("relock_short.locked", locked, 1);

    // hsync stuck high: x saturates, a single fmt_err pulse, lock lost.
    while (!(gx == 0 && gy == 5)) cycle(1'b0);
    chk_en   = 0;
    good     = 0;
    exp_lock = 0;
    nfmt     = 0;
    repeat (5000) cycle(1'b1);
    chk("stall.x_sat", x_poi, 4095);
    chk("stall.locked", locked, 0);
    q.delete();
    chk_en = 1;
    repeat (60) cycle(1'b0);
    chk("stall.fmt_pulses", nfmt, 1);
    run_starts(4);
    chk("relock_stall.locked", locked, 1);

    // Switch timing at a frame boundary while locked.
    while (!(gx == 0 && gy == 0)) cycle(1'b0);
    h_tot = 52;
    h_sw  = 8;
    v_tot = 36;
    v_sw  = 4;
    cycle(1'b0);
    good = 1;
    run_starts(3);
    repeat (3) cycle(1'b0);
    chk_meas("switch", 52, 8, 36, 4);

    // Asynchronous reset mid-line while locked, then reacquire.
    while (gx != 17) cycle(1'b0);
    #3 rst_n = 1'b0;
    #1;
    chk_zero("async_rst");
    chk_en   = 0;
    q.delete();
    good     = 0;
    exp_lock = 0;
    hit_next = 0;
    gx       = 0;
    gy       = 0;
    hsync_in = 1'b1;
    vsync_in = 1'b1;
    repeat (3) @(posedge vga_clk);
    #1 rst_n = 1'b1;
    chk_en = 1;
    run_starts(4);
    repeat (3) cycle(1'b0);
    chk_meas("relock_rst", 52, 8, 36, 4);
    chk("relock_rst.locked", locked, 1);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
